serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial (or digit-serial) adder/subtractor: BITS_PER_CYCLE bits are added
// per clock through a shared carry, with a one-cycle done pulse per result.
module serial_addsub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]        a_sr;
    logic [WIDTH-1:0]        b_sr;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        acc_next;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic [BITS_PER_CYCLE:0] chunk;
    logic                    msb_carry_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is masked by reset so nothing upstream sees it during reset.
    assign ready = rst_n && (state == IDLE);
    assign done  = (state == DONE);

    always_comb begin
        chunk = {1'b0, a_sr[BITS_PER_CYCLE-1:0]}
              + {1'b0, b_sr[BITS_PER_CYCLE-1:0]}
              + {{BITS_PER_CYCLE{1'b0}}, carry};
        acc_next = WIDTH'({chunk[BITS_PER_CYCLE-1:0], acc} >> BITS_PER_CYCLE);
        // The carry into the top bit of this digit is recovered from its sum bit.
        msb_carry_in = chunk[BITS_PER_CYCLE-1]
                     ^ a_sr[BITS_PER_CYCLE-1]
                     ^ b_sr[BITS_PER_CYCLE-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> BITS_PER_CYCLE;
            b_sr  <= b_sr >> BITS_PER_CYCLE;
            acc   <= acc_next;
            carry <= chunk[BITS_PER_CYCLE];
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                sum      <= acc_next;
                cout     <= chunk[BITS_PER_CYCLE];
                overflow <= msb_carry_in ^ chunk[BITS_PER_CYCLE];
            end
        end
    end

endmodule
